uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : 8N1 UART transmitter fed by a power-of-two byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rstN,
    input  logic [7:0]                          txData,
    input  logic                                txValid,
    output logic                                txReady,
    output logic                                tx,
    output logic                                txBusy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifoCount
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q,  count_d;
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  baud_q,   baud_d;
    logic [2:0]        bit_q,    bit_d;
    logic [7:0]        shift_q,  shift_d;
    logic              tx_q,     tx_d;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_end;

    // Storage has no reset: contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= txData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        w_pop      = 1'b0;
        w_push     = txValid && txReady;
        w_baud_end = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (count_q != '0) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        txBusy    = (state_q != S_IDLE);
        txReady   = (count_q != FIFO_FULL);
        tx        = tx_q;
        fifoCount = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed bench for uart_tx_fifo at BAUD_DIV=10, FIFO_DEPTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       tx;
    logic       txBusy;
    logic [2:0] fifoCount;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .txData    (txData),
        .txValid   (txValid),
        .txReady   (txReady),
        .tx        (tx),
        .txBusy    (txBusy),
        .fifoCount (fifoCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Decodes one frame; 'skip' is how many start-bit samples are already past.
    task automatic rx_frame(input logic [7:0] exp, input string tag, input int skip, input int exp_wait);
        int         waited;
        logic [9:0] rx;
        logic       stable;
        logic       busy_ok;
        logic       first;
        waited = 0;
        if (skip == 0) begin
            while (tx !== 1'b0 && waited < 200) begin
                tick();
                waited++;
            end
            check({tag, "_start_seen"}, 32'(tx), 0);
            if (exp_wait >= 0) check({tag, "_gap"}, waited, exp_wait);
        end
        if (tx === 1'b0) begin
            stable  = 1'b1;
            busy_ok = 1'b1;
            rx      = '0;
            first   = 1'b0;
            for (int i = skip; i < 100; i++) begin
                if (i % 10 == 0 || i == skip) first = tx;
                else if (tx !== first) stable = 1'b0;
                if (i % 10 == 5) rx[i / 10] = tx;
                if (txBusy !== 1'b1) busy_ok = 1'b0;
                if (i < 99) tick();
            end
            check({tag, "_startbit"}, 32'(rx[0]), 0);
            check({tag, "_stopbit"},  32'(rx[9]), 1);
            check({tag, "_data"},     32'(rx[8:1]), 32'(exp));
            check({tag, "_timing"},   32'(stable), 1);
            check({tag, "_busy"},     32'(busy_ok), 1);
        end
    endtask

    initial begin
        int low;

        rstN    = 1'b0;
        txValid = 1'b0;
        txData  = 8'h00;
        repeat (3) tick();
        check("rst_tx",    32'(tx), 1);
        check("rst_busy",  32'(txBusy), 0);
        check("rst_ready", 32'(txReady), 1);
        check("rst_count", 32'(fifoCount), 0);
        rstN = 1'b1;
        tick();

        // Single byte into an idle block.
        txData = 8'hA5; txValid = 1'b1; tick(); txValid = 1'b0;
        check("t1_tx_edgeN", 32'(tx), 1);
        check("t1_count",    32'(fifoCount), 1);
        rx_frame(8'hA5, "t1", 0, 1);
        tick();
        check("t1_busy_fall", 32'(txBusy), 0);
        check("t1_tx_idle",   32'(tx), 1);
        check("t1_count_end", 32'(fifoCount), 0);

        // Three bytes back to back.
        txValid = 1'b1;
        txData = 8'h00; tick(); check("t2_count1", 32'(fifoCount), 1);
        txData = 8'hFF; tick(); check("t2_count2", 32'(fifoCount), 1);
        check("t2_tx_low", 32'(tx), 0);
        txData = 8'h55; tick(); check("t2_count3", 32'(fifoCount), 2);
        txValid = 1'b0;
        rx_frame(8'h00, "t2a", 1, -1);
        rx_frame(8'hFF, "t2b", 0, 1);
        rx_frame(8'h55, "t2c", 0, 1);
        tick();
        check("t2_idle", 32'(txBusy), 0);

        // Fill: 20 cycles of valid, only 0..4 accepted.
        for (int k = 0; k < 20; k++) begin
            txData  = 8'(k);
            txValid = 1'b1;
            tick();
            if (k == 0)  check("t3_count_k0", 32'(fifoCount), 1);
            if (k == 1)  check("t3_count_k1", 32'(fifoCount), 1);
            if (k == 3)  check("t3_ready_k3", 32'(txReady), 1);
            if (k == 4)  check("t3_ready_k4", 32'(txReady), 0);
            if (k == 4)  check("t3_count_k4", 32'(fifoCount), 4);
            if (k == 19) check("t3_ready_k19", 32'(txReady), 0);
            if (k == 19) check("t3_count_k19", 32'(fifoCount), 4);
        end
        txValid = 1'b0;
        rx_frame(8'h00, "t3_0", 18, -1);
        for (int b = 1; b < 5; b++) rx_frame(8'(b), $sformatf("t3_%0d", b), 0, 1);
        tick();
        check("t3_idle_busy",  32'(txBusy), 0);
        check("t3_idle_count", 32'(fifoCount), 0);

        // Push on the same edge as a pop.
        txValid = 1'b1;
        txData = 8'h11; tick();
        txData = 8'h22; tick();
        txData = 8'h33; tick();
        txValid = 1'b0;
        check("t5_count_pre", 32'(fifoCount), 2);
        rx_frame(8'h11, "t5a", 1, -1);
        check("t5_count_before_pop", 32'(fifoCount), 2);
        txData = 8'h44; txValid = 1'b1; tick(); txValid = 1'b0;
        check("t5_pushpop_count", 32'(fifoCount), 2);
        check("t5_pushpop_tx",    32'(tx), 0);
        rx_frame(8'h22, "t5b", 0, 0);
        rx_frame(8'h33, "t5c", 0, 1);
        rx_frame(8'h44, "t5d", 0, 1);
        tick();
        check("t5_idle", 32'(txBusy), 0);

        // Back-pressure: 0xEE offered while full.
        for (int k = 0; k < 5; k++) begin
            txData  = 8'(32'h60 + k);
            txValid = 1'b1;
            tick();
        end
        txData = 8'hEE; tick(); txValid = 1'b0;
        check("t6_full_count", 32'(fifoCount), 4);
        check("t6_full_ready", 32'(txReady), 0);
        rx_frame(8'h60, "t6_0", 4, -1);
        for (int b = 1; b < 5; b++) rx_frame(8'(32'h60 + b), $sformatf("t6_%0d", b), 0, 1);
        low = 0;
        repeat (150) begin
            tick();
            if (tx !== 1'b1) low++;
        end
        check("t6_no_extra_frame", low, 0);
        check("t6_count_end", 32'(fifoCount), 0);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        txValid = 1'b1;
        txData = 8'h3C; tick();
        txData = 8'h01; tick();
        txData = 8'h02; tick();
        txValid = 1'b0;
        repeat (43) tick();
        check("t4_bit3",       32'(tx), 1);
        check("t4_busy_pre",   32'(txBusy), 1);
        check("t4_count_pre",  32'(fifoCount), 2);
        #2 rstN = 1'b0;
        #1;
        check("t4_async_tx",    32'(tx), 1);
        check("t4_async_busy",  32'(txBusy), 0);
        check("t4_async_count", 32'(fifoCount), 0);
        check("t4_async_ready", 32'(txReady), 1);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        check("t4_post_count", 32'(fifoCount), 0);
        check("t4_post_ready", 32'(txReady), 1);
        check("t4_post_tx",    32'(tx), 1);
        txData = 8'h81; txValid = 1'b1; tick(); txValid = 1'b0;
        rx_frame(8'h81, "t4_new", 0, 1);
        low = 0;
        repeat (30) begin
            tick();
            if (tx !== 1'b1 || txBusy !== 1'b0) low++;
        end
        check("t4_discarded", low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
